// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
// Counter widths up to 32 bits are supported by eff_div.
package tick_gen_pkg;

    typedef enum logic {
        TICK_PERIODIC = 1'b0,
        TICK_ONESHOT  = 1'b1
    } tick_mode_e;

    localparam int DEFAULT_DIV_C = 28;

    // A divide value of 0 behaves like 1: tick on every enabled cycle.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: counter, programmable divide/mode, one-shot armed flag.
// Strobes arrive already qualified for this channel; priority is sync > cfg > start > en.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = DEFAULT_DIV_C,
    parameter int DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_hit,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             sync,
    output logic             tick,
    output logic             busy
);

    localparam tick_mode_e RESET_MODE = (DEFAULT_MODE != 0) ? TICK_ONESHOT : TICK_PERIODIC;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    tick_mode_e       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             last;

    assign last = (32'(cnt_q) == eff_div(32'(div_q)) - 32'd1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        mode_d = mode_q;
        busy_d = busy_q;
        tick_d = 1'b0;

        if (sync) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (cfg_hit) begin
            div_d  = cfg_div;
            mode_d = cfg_mode ? TICK_ONESHOT : TICK_PERIODIC;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start) begin
            cnt_d  = '0;
            busy_d = (mode_q == TICK_ONESHOT);
        end else if (!en) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (mode_q == TICK_PERIODIC || busy_q) begin
            if (last) begin
                tick_d = 1'b1;
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Idle one-shot channel holds its counter at zero until the next start.
            cnt_d = '0;
        end
    end

    // NOTE: reset is synchronous, so rst is only looked at inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: state registers update with non-blocking assignments so all channels see pre-edge values.
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            mode_q <= RESET_MODE;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: decodes the config address and
// fans the global sync out to NUM_CH independent tick_channel instances.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = DEFAULT_DIV_C,
    parameter int DEFAULT_MODE = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] start,
    input  logic              sync_all,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] cfg_hit;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Addresses at or above NUM_CH match no channel, so such writes are dropped.
        assign cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_DIV  (DEFAULT_DIV),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .cfg_hit  (cfg_hit[i]),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .start    (start[i]),
            .sync     (sync_all),
            .tick     (tick[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: a vector table, directed multi-cycle
// sequences and randomized traffic against a time-based reference model.
module tb_tick_gen_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_mode;
    logic [3:0]  start;
    logic        sync_all;
    logic [3:0]  tick, busy;
    logic [2:0]  tick3, busy3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_gen_multi #(.NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .start(start),
        .sync_all(sync_all), .tick(tick), .busy(busy)
    );

    // Three-channel copy: cfg_ch==3 is out of range here and must be dropped.
    tick_gen_multi #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .start(start[2:0]),
        .sync_all(sync_all), .tick(tick3), .busy(busy3)
    );

    // Reference model: each channel remembers the posedge at which its phase
    // last restarted; ticks follow from elapsed time modulo the divide.
    int         cyc = 0;
    int         m_origin[4];
    int         m_div[4];
    bit         m_mode[4];
    bit         m_armed[4];
    logic [3:0] m_tick, m_busy;

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < 4; i++) begin
            int eff;
            m_tick[i] = 1'b0;
            if (!rst) begin
                m_div[i] = 28; m_mode[i] = 1'b0; m_armed[i] = 1'b0; m_origin[i] = cyc;
            end else if (sync_all) begin
                m_armed[i] = 1'b0; m_origin[i] = cyc;
            end else if (cfg_we && cfg_ch == 2'(i)) begin
                m_div[i] = int'(cfg_div); m_mode[i] = cfg_mode; m_armed[i] = 1'b0; m_origin[i] = cyc;
            end else if (start[i]) begin
                m_armed[i] = m_mode[i]; m_origin[i] = cyc;
            end else if (!en[i]) begin
                m_armed[i] = 1'b0; m_origin[i] = cyc;
            end else begin
                eff = (m_div[i] == 0) ? 1 : m_div[i];
                if (!m_mode[i]) begin
                    m_tick[i] = ((cyc - m_origin[i]) % eff == 0);
                end else if (m_armed[i] && (cyc - m_origin[i] == eff)) begin
                    m_tick[i] = 1'b1;
                    m_armed[i] = 1'b0;
                end
            end
            m_busy[i] = m_armed[i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: advance model at the edge, compare both DUTs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model_tick", 32'(tick), 32'(m_tick));
        check("model_busy", 32'(busy), 32'(m_busy));
        check("dut3_tick", 32'(tick3), 32'(m_tick[2:0]));
        check("dut3_busy", 32'(busy3), 32'(m_busy[2:0]));
    endtask

    task automatic idle();
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 16'd0;
        cfg_mode = 1'b0; start = 4'h0; sync_all = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] div, input logic mode);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = div; cfg_mode = mode;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        mode;
        logic [3:0]  start;
        logic        sync;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        idle();
        en = 4'hF;

        // rst en we ch div mode start sync | tick busy
        vecs[0]  = '{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 4'hF, 1'b1, 2'd3, 16'd0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
        vecs[2]  = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h0};
        vecs[3]  = '{1'b1, 4'hF, 1'b1, 2'd3, 16'd1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
        vecs[4]  = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h0};
        vecs[5]  = '{1'b1, 4'h7, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};
        vecs[6]  = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h0};
        vecs[7]  = '{1'b1, 4'hF, 1'b1, 2'd2, 16'd2, 1'b1, 4'h0, 1'b0, 4'h8, 4'h0};
        vecs[8]  = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h4, 1'b0, 4'h8, 4'h4};
        vecs[9]  = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h4};
        vecs[10] = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'hC, 4'h0};
        vecs[11] = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h0};
        vecs[12] = '{1'b1, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0};
        vecs[13] = '{1'b0, 4'hF, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0};

        for (int v = 0; v < 14; v++) begin
            rst = vecs[v].rst; en = vecs[v].en; cfg_we = vecs[v].we; cfg_ch = vecs[v].ch;
            cfg_div = vecs[v].div; cfg_mode = vecs[v].mode; start = vecs[v].start;
            sync_all = vecs[v].sync;
            step();
            check($sformatf("vec%0d_tick", v), 32'(tick), 32'(vecs[v].exp_tick));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
        end

        // Legacy divide-by-28 behaviour on all channels.
        do_reset();
        en = 4'hF;
        for (int k = 1; k <= 90; k++) begin
            step();
            check("legacy_tick", 32'(tick), (k % 28 == 0) ? 32'hF : 32'h0);
            check("legacy_busy", 32'(busy), 32'h0);
        end

        // Reprogram channel 1 to divide-by-5 at posedge 10.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            if (k == 10) cfg(2'd1, 16'd5, 1'b0); else cfg_we = 1'b0;
            step();
            check("div5_tick1", 32'(tick[1]), 32'(k > 10 && (k - 10) % 5 == 0));
            check("div5_tick0", 32'(tick[0]), 32'(k == 28));
        end

        // One-shot on channel 2: single shot, idle restart, retrigger.
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            if (k == 1) cfg(2'd2, 16'd3, 1'b1); else cfg_we = 1'b0;
            start = (k == 40 || k == 50 || k == 52) ? 4'h4 : 4'h0;
            step();
            check("oneshot_tick2", 32'(tick[2]), 32'(k == 43 || k == 55));
            check("oneshot_busy2", 32'(busy[2]),
                  32'((k >= 40 && k <= 42) || (k >= 50 && k <= 54)));
        end
        start = 4'h0;

        // Global sync re-aligns channels that were at different phases.
        do_reset();
        for (int k = 1; k <= 130; k++) begin
            if (k == 3) cfg(2'd1, 16'd5, 1'b0); else cfg_we = 1'b0;
            sync_all = (k == 100);
            step();
            if (k > 100) begin
                check("sync_tick0", 32'(tick[0]), 32'(k == 128));
                check("sync_tick1", 32'(tick[1]), 32'((k - 100) % 5 == 0));
                check("sync_tick3", 32'(tick[3]), 32'(k == 128));
            end
        end
        sync_all = 1'b0;

        // Reset in the middle of counting and during an armed one-shot.
        cfg(2'd2, 16'd6, 1'b1);
        step();
        idle();
        start = 4'h4;
        step();
        start = 4'h0;
        step();
        check("pre_rst_busy2", 32'(busy[2]), 32'h1);
        rst = 1'b0;
        cfg(2'd0, 16'd3, 1'b0);
        start = 4'hF;
        sync_all = 1'b1;
        step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        idle();
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) cfg(2'd3, 16'd2, 1'b0); else cfg_we = 1'b0;
            step();
            check("post_rst_tick0", 32'(tick[0]), 32'(k == 28));
            check("post_rst_tick3", 32'(tick[3]), 32'(k > 5 && (k - 5) % 2 == 0));
            check("dut3_ignore_tick", 32'(tick3), (k == 28) ? 32'h7 : 32'h0);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(199) != 0);
            sync_all = ($urandom_range(99) == 0);
            cfg_we   = ($urandom_range(29) == 0);
            cfg_ch   = 2'($urandom_range(3));
            cfg_div  = ($urandom_range(3) == 0) ? 16'($urandom_range(40)) : 16'($urandom_range(6));
            cfg_mode = 1'($urandom_range(1));
            for (int i = 0; i < 4; i++) begin
                start[i] = ($urandom_range(19) == 0);
                en[i]    = ($urandom_range(14) != 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
